kinase_ctrl_sequencer: RTL and testbench

- Off-chip electronic driver for the control side of the kinase activity chip: drives its 13 valve lines, 4 select lines, 3-valve peristaltic pump A and 2-valve pump B.
- Accepts one "step" command at a time over a valid/ready handshake.
- Each step applies a valve/select pattern, waits a settle time, runs the chosen pump for N cycles, then reports completion.
- Sits between the host-side protocol sequencer and the solenoid driver board.

---
 rtl/kinase_ctrl_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_kinase_ctrl_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kinase_ctrl_sequencer.sv
// Step sequencer for the kinase chip control side: valve/select pattern, settle, pump, done.
// Optional PUMP_REVERSE_EN adds cmd_reverse to run the pump phase sequence backwards.
module kinase_ctrl_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int PHASE_CYCLES  = 8,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [12:0] cmd_valves,
    input  logic [3:0]  cmd_select,
    input  logic [1:0]  cmd_pump,
    input  logic [7:0]  cmd_cycles,
`ifdef PUMP_REVERSE_EN
    input  logic        cmd_reverse,
`endif
    input  logic        abort,
    output logic [12:0] pad_ctrl_a,
    output logic [3:0]  pad_ctrl_s,
    output logic [2:0]  pad_pump_a,
    output logic [1:0]  pad_pump_b,
    output logic        busy,
    output logic        step_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        PUMP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHASE_LOAD  = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [2:0]        phase_r, phase_n;
    logic [7:0]        cyc_r, cyc_n;
    logic [1:0]        pump_r, pump_n;
    logic              rev_r, rev_n;
    logic [12:0]       ctrl_a_r, ctrl_a_n;
    logic [3:0]        ctrl_s_r, ctrl_s_n;
    logic [2:0]        pump_a_r, pump_a_n;
    logic [1:0]        pump_b_r, pump_b_n;
    logic              busy_r, busy_n;
    logic              done_r, done_n;
    logic              ready_r, ready_n;
    logic              rev_in_s;
    logic              last_phase_s;
    logic [2:0]        phase_inc_s;

`ifdef PUMP_REVERSE_EN
    assign rev_in_s = cmd_reverse;
`else
    assign rev_in_s = 1'b0;
`endif

    assign phase_inc_s  = phase_r + 3'd1;
    assign last_phase_s = (pump_r == 2'd1) ? (phase_r == 3'd5) : (phase_r == 3'd1);

    // Pump A valve pattern for a phase index; zero unless pump A is selected.
    function automatic logic [2:0] drive_a(input logic [1:0] sel, input logic [2:0] idx,
                                           input logic rev);
        logic [2:0] k;
        logic [2:0] pat;
        k = rev ? (3'd5 - idx) : idx;
        case (k)
            3'd0:    pat = 3'b100;
            3'd1:    pat = 3'b110;
            3'd2:    pat = 3'b010;
            3'd3:    pat = 3'b011;
            3'd4:    pat = 3'b001;
            3'd5:    pat = 3'b101;
            default: pat = 3'b000;
        endcase
        if (sel == 2'd1) begin
            return pat;
        end else begin
            return 3'b000;
        end
    endfunction

    // Pump B valve pattern for a phase index; zero unless pump B is selected.
    function automatic logic [1:0] drive_b(input logic [1:0] sel, input logic idx,
                                           input logic rev);
        if (sel != 2'd2) begin
            return 2'b00;
        end else if (idx ^ rev) begin
            return 2'b01;
        end else begin
            return 2'b10;
        end
    endfunction

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        phase_n  = phase_r;
        cyc_n    = cyc_r;
        pump_n   = pump_r;
        rev_n    = rev_r;
        ctrl_a_n = ctrl_a_r;
        ctrl_s_n = ctrl_s_r;
        pump_a_n = pump_a_r;
        pump_b_n = pump_b_r;
        busy_n   = busy_r;
        done_n   = 1'b0;
        ready_n  = ready_r;
        if (abort) begin
            // Abort wins in every state, including over a command offered in IDLE.
            state_n  = IDLE;
            cnt_n    = CNT_ZERO;
            phase_n  = 3'd0;
            cyc_n    = 8'd0;
            ctrl_a_n = 13'd0;
            ctrl_s_n = 4'd0;
            pump_a_n = 3'd0;
            pump_b_n = 2'd0;
            busy_n   = 1'b0;
            ready_n  = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                    if (cmd_valid) begin
                        state_n  = SETTLE;
                        cnt_n    = SETTLE_LOAD;
                        phase_n  = 3'd0;
                        ctrl_a_n = cmd_valves;
                        ctrl_s_n = cmd_select;
                        pump_n   = cmd_pump;
                        cyc_n    = cmd_cycles;
                        rev_n    = rev_in_s;
                        busy_n   = 1'b1;
                        ready_n  = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                SETTLE: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_n = cnt_r - CNT_ONE;
                    end else if ((pump_r == 2'd1 || pump_r == 2'd2) && cyc_r != 8'd0) begin
                        state_n  = PUMP;
                        cnt_n    = PHASE_LOAD;
                        phase_n  = 3'd0;
                        pump_a_n = drive_a(pump_r, 3'd0, rev_r);
                        pump_b_n = drive_b(pump_r, 1'b0, rev_r);
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
                PUMP: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_n = cnt_r - CNT_ONE;
                    end else if (!last_phase_s) begin
                        cnt_n    = PHASE_LOAD;
                        phase_n  = phase_inc_s;
                        pump_a_n = drive_a(pump_r, phase_inc_s, rev_r);
                        pump_b_n = drive_b(pump_r, phase_inc_s[0], rev_r);
                    end else if (cyc_r > 8'd1) begin
                        cnt_n    = PHASE_LOAD;
                        cyc_n    = cyc_r - 8'd1;
                        phase_n  = 3'd0;
                        pump_a_n = drive_a(pump_r, 3'd0, rev_r);
                        pump_b_n = drive_b(pump_r, 1'b0, rev_r);
                    end else begin
                        state_n  = DONE;
                        pump_a_n = 3'd0;
                        pump_b_n = 2'd0;
                        done_n   = 1'b1;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                end
                default: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    ready_n = 1'b1;
                end
            endcase
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            phase_r  <= 3'd0;
            cyc_r    <= 8'd0;
            pump_r   <= 2'd0;
            rev_r    <= 1'b0;
            ctrl_a_r <= 13'd0;
            ctrl_s_r <= 4'd0;
            pump_a_r <= 3'd0;
            pump_b_r <= 2'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            phase_r  <= phase_n;
            cyc_r    <= cyc_n;
            pump_r   <= pump_n;
            rev_r    <= rev_n;
            ctrl_a_r <= ctrl_a_n;
            ctrl_s_r <= ctrl_s_n;
            pump_a_r <= pump_a_n;
            pump_b_r <= pump_b_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            ready_r  <= ready_n;
        end
    end

    assign cmd_ready  = ready_r;
    assign pad_ctrl_a = ctrl_a_r;
    assign pad_ctrl_s = ctrl_s_r;
    assign pad_pump_a = pump_a_r;
    assign pad_pump_b = pump_b_r;
    assign busy       = busy_r;
    assign step_done  = done_r;

endmodule

// File: tb/tb_kinase_ctrl_sequencer.sv
// Self-checking bench for kinase_ctrl_sequencer: per-cycle output traces expanded from the step rules.
module tb_kinase_ctrl_sequencer;

    localparam int S = 4;
    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [12:0] cmd_valves;
    logic [3:0]  cmd_select;
    logic [1:0]  cmd_pump;
    logic [7:0]  cmd_cycles;
    logic        cmd_reverse;
    logic        abort;
    logic [12:0] pad_ctrl_a;
    logic [3:0]  pad_ctrl_s;
    logic [2:0]  pad_pump_a;
    logic [1:0]  pad_pump_b;
    logic        busy;
    logic        step_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [12:0] a;
        logic [3:0]  s;
        logic [2:0]  pa;
        logic [1:0]  pb;
        logic        busy;
        logic        done;
        logic        ready;
        logic        first;
    } rec_t;

    typedef struct {
        logic [12:0] v;
        logic [3:0]  s;
        logic [1:0]  p;
        logic [7:0]  c;
        logic        r;
    } cmd_t;

    cmd_t cmd_q[$];
    rec_t exp_q[$];
    rec_t obs_q[$];
    rec_t zero_rec;

    kinase_ctrl_sequencer #(.SETTLE_CYCLES(S), .PHASE_CYCLES(P), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_valves(cmd_valves), .cmd_select(cmd_select), .cmd_pump(cmd_pump),
        .cmd_cycles(cmd_cycles),
`ifdef PUMP_REVERSE_EN
        .cmd_reverse(cmd_reverse),
`endif
        .abort(abort), .pad_ctrl_a(pad_ctrl_a), .pad_ctrl_s(pad_ctrl_s),
        .pad_pump_a(pad_pump_a), .pad_pump_b(pad_pump_b), .busy(busy), .step_done(step_done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic rec_t observe();
        return {pad_ctrl_a, pad_ctrl_s, pad_pump_a, pad_pump_b, busy, step_done, cmd_ready, 1'b0};
    endfunction

    // Reference: expand one step into the per-cycle outputs seen from t0+1 to the idle cycle after DONE.
    task automatic model_step(input cmd_t c);
        logic [2:0] sa [6];
        logic [1:0] sb [2];
        logic       rev;
        int         len;
        int         pi;
        rec_t       r;
        sa  = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        sb  = '{2'b10, 2'b01};
        rev = c.r;
`ifndef PUMP_REVERSE_EN
        rev = 1'b0;
`endif
        for (int k = 0; k < S; k++) begin
            r = {c.v, c.s, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, (k == 0)};
            exp_q.push_back(r);
        end
        if ((c.p == 2'd1 || c.p == 2'd2) && c.c != 8'd0) begin
            len = (c.p == 2'd1) ? 6 : 2;
            for (int cy = 0; cy < int'(c.c); cy++)
                for (int ph = 0; ph < len; ph++)
                    for (int rr = 0; rr < P; rr++) begin
                        pi = rev ? (len - 1 - ph) : ph;
                        r = {c.v, c.s, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
                        if (c.p == 2'd1) r.pa = sa[pi];
                        else             r.pb = sb[pi];
                        exp_q.push_back(r);
                    end
        end
        r = {c.v, c.s, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_q.push_back(r);
        r = {c.v, c.s, 3'b000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_q.push_back(r);
    endtask

    task automatic present(input cmd_t c);
        cmd_valves  = c.v;
        cmd_select  = c.s;
        cmd_pump    = c.p;
        cmd_cycles  = c.c;
        cmd_reverse = c.r;
    endtask

    // Drive cmd_q with cmd_valid held until the last command is accepted; record outputs each cycle.
    task automatic execute(input int abort_at, input int extra);
        int ci;
        obs_q = {};
        exp_q = {};
        foreach (cmd_q[k]) model_step(cmd_q[k]);
        @(negedge clk);
        present(cmd_q[0]);
        cmd_valid = 1'b1;
        ci = 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (exp_q[i].first) begin
                if (ci < cmd_q.size()) begin
                    present(cmd_q[ci]);
                    ci++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            obs_q.push_back(observe());
            if (i == abort_at) begin
                abort     = 1'b1;
                cmd_valid = 1'b0;
                for (int j = 0; j < extra; j++) begin
                    @(negedge clk);
                    abort = 1'b0;
                    obs_q.push_back(observe());
                end
                break;
            end
        end
    endtask

    function automatic cmd_t mk(input logic [12:0] v, input logic [3:0] s, input logic [1:0] p,
                                input logic [7:0] c, input logic r);
        cmd_t x;
        x.v = v; x.s = s; x.p = p; x.c = c; x.r = r;
        return x;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (observe() !== zero_rec) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", observe(), zero_rec);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (observe() !== zero_rec) begin
            errors++;
            $display("FAIL reset_release got %h want %h", observe(), zero_rec);
        end
    endtask

    task automatic test_trace(input string name, input int abort_at, input int extra);
        rec_t e;
        execute(abort_at, extra);
        for (int i = 0; i < obs_q.size(); i++) begin
            if (abort_at >= 0 && i > abort_at) e = zero_rec;
            else begin
                e = exp_q[i];
                e.first = 1'b0;
            end
            checks++;
            if (obs_q[i] !== e) begin
                errors++;
                $display("FAIL %s cycle t0+%0d got a=%h s=%h pa=%b pb=%b busy=%b done=%b rdy=%b want a=%h s=%h pa=%b pb=%b busy=%b done=%b rdy=%b",
                         name, i + 1, obs_q[i].a, obs_q[i].s, obs_q[i].pa, obs_q[i].pb, obs_q[i].busy,
                         obs_q[i].done, obs_q[i].ready, e.a, e.s, e.pa, e.pb, e.busy, e.done, e.ready);
            end
        end
    endtask

    task automatic test_settle_only();
        cmd_q = {};
        cmd_q.push_back(mk(13'h1A5, 4'h9, 2'd0, 8'd3, 1'b0));
        test_trace("settle_only", -1, 0);
    endtask

    task automatic test_pump_a();
        cmd_q = {};
        cmd_q.push_back(mk(13'h0F3, 4'h5, 2'd1, 8'd1, 1'b0));
        test_trace("pump_a", -1, 0);
    endtask

    task automatic test_pump_a_reverse();
        cmd_q = {};
        cmd_q.push_back(mk(13'h155, 4'h6, 2'd1, 8'd1, 1'b1));
        test_trace("pump_a_reverse", -1, 0);
    endtask

    task automatic test_pump_b();
        cmd_q = {};
        cmd_q.push_back(mk(13'h1FF, 4'hF, 2'd2, 8'd2, 1'b0));
        test_trace("pump_b", -1, 0);
    endtask

    task automatic test_abort_pump();
        cmd_q = {};
        cmd_q.push_back(mk(13'h0AA, 4'h3, 2'd1, 8'd2, 1'b0));
        test_trace("abort_pump", S + 2 * P, 4);
    endtask

    task automatic test_abort_idle();
        @(negedge clk);
        present(mk(13'h1C1, 4'hA, 2'd2, 8'd1, 1'b0));
        cmd_valid = 1'b1;
        abort     = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            abort     = 1'b0;
            cmd_valid = 1'b0;
            checks++;
            if (observe() !== zero_rec) begin
                errors++;
                $display("FAIL abort_idle cycle %0d got %h want %h", j, observe(), zero_rec);
            end
        end
    endtask

    task automatic test_back_to_back();
        cmd_q = {};
        cmd_q.push_back(mk(13'h123, 4'h1, 2'd2, 8'd1, 1'b0));
        cmd_q.push_back(mk(13'h0F0, 4'hC, 2'd0, 8'd0, 1'b0));
        cmd_q.push_back(mk(13'h1E7, 4'h7, 2'd1, 8'd1, 1'b1));
        test_trace("back_to_back", -1, 0);
    endtask

    task automatic test_max_cycles();
        cmd_q = {};
        cmd_q.push_back(mk(13'h001, 4'h2, 2'd2, 8'd255, 1'b0));
        test_trace("max_cycles", -1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            cmd_q = {};
            cmd_q.push_back(mk(13'($urandom), 4'($urandom), 2'($urandom_range(0, 3)),
                               8'($urandom_range(0, 3)), 1'($urandom)));
            if (n % 3 == 2) test_trace("random_abort", int'($urandom_range(0, S + 6)), 3);
            else            test_trace("random", -1, 0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        present(mk(13'h0C3, 4'h4, 2'd1, 8'd2, 1'b0));
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (S + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (observe() !== zero_rec) begin
                errors++;
                $display("FAIL reset_mid cycle %0d got %h want %h", j, observe(), zero_rec);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        zero_rec    = {13'd0, 4'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_valves  = 13'd0;
        cmd_select  = 4'd0;
        cmd_pump    = 2'd0;
        cmd_cycles  = 8'd0;
        cmd_reverse = 1'b0;
        abort       = 1'b0;
        test_reset();
        test_settle_only();
        test_pump_a();
        test_pump_b();
        test_abort_idle();
        test_pump_a_reverse();
        test_abort_pump();
        test_back_to_back();
        test_max_cycles();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
